// File: rtl/falling_sand_pkg.sv
// Shared constants and types for the falling-sand VRAM path.
package falling_sand_pkg;

  // Screen geometry: one VRAM cell per pixel.
  localparam int unsigned VRAM_COLUMNS = 640;
  localparam int unsigned VRAM_ROWS    = 400;
  localparam int unsigned VRAM_CELLS   = VRAM_COLUMNS * VRAM_ROWS;

  // Cell encodings stored in VRAM.
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_SAND  = 2'b01;
  localparam logic [1:0] CELL_WALL  = 2'b10;
  localparam logic [1:0] CELL_WATER = 2'b11;

  // Write arbiter FSM states.
  typedef enum logic {
    StArb,
    StClear
  } arb_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; DEPTH must be a power of two (>= 2).
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Extra MSB distinguishes full from empty when the index bits match.
  logic [PtrW:0]    wr_ptr_q, rd_ptr_q;
  logic             push_ok, pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q[PtrW-1:0]];

  // Pointer registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage; contents are only observed when non-empty, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[PtrW-1:0]] <= din_i;
  end

endmodule

// File: rtl/vram_write_arbiter.sv
// Arbitrates game-state and buffered mouse-draw writes onto a single registered
// VRAM write port, with a full-VRAM clear sequence that preempts both sources.
module vram_write_arbiter
  import falling_sand_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned RAM_LENGTH = VRAM_CELLS,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  gst_wr_en_i,
  input  logic [ADDR_WIDTH-1:0] gst_wr_address_i,
  input  logic [DATA_WIDTH-1:0] gst_wr_data_i,
  output logic                  gst_ready_o,
  input  logic                  mpd_wr_en_i,
  input  logic [ADDR_WIDTH-1:0] mpd_wr_address_i,
  input  logic [DATA_WIDTH-1:0] mpd_wr_data_i,
  output logic                  mpd_ready_o,
  output logic                  mpd_drop_o,
  input  logic                  clr_start_i,
  output logic                  clr_busy_o,
  output logic                  clr_done_o,
  output logic                  vram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] vram_wr_address_o,
  output logic [DATA_WIDTH-1:0] vram_wr_data_o
);

  localparam int unsigned EntryW = ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
  localparam int unsigned ClrW   = (RAM_LENGTH > 1) ? $clog2(RAM_LENGTH) : 1;
  localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_BURST);
  localparam logic [ClrW-1:0]   ClrLast  = ClrW'(RAM_LENGTH - 1);

  arb_state_e            state_q, state_d;
  logic [BurstW-1:0]     burst_q, burst_d;
  logic [ClrW-1:0]       clr_cnt_q, clr_cnt_d;
  logic                  done_q, done_d;
  logic                  drop_q, drop_d;
  logic                  vram_en_q, vram_en_d;
  logic [ADDR_WIDTH-1:0] vram_addr_q, vram_addr_d;
  logic [DATA_WIDTH-1:0] vram_data_q, vram_data_d;
  logic                  gst_ready;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [EntryW-1:0]     fifo_din, fifo_dout;

  // Mouse writes are accepted purely on FIFO space; a pop in the same cycle
  // does not rescue a write offered while full.
  assign fifo_push = mpd_wr_en_i && !fifo_full;
  assign drop_d    = mpd_wr_en_i && fifo_full;
  assign fifo_din  = {mpd_wr_address_i, mpd_wr_data_i};

  sync_fifo #(
    .WIDTH(EntryW),
    .DEPTH(FIFO_DEPTH)
  ) u_mpd_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .push_i (fifo_push),
    .din_i  (fifo_din),
    .pop_i  (fifo_pop),
    .dout_o (fifo_dout),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Grant selection, burst accounting, clear sequencing and next VRAM write.
  always_comb begin
    state_d     = state_q;
    burst_d     = burst_q;
    clr_cnt_d   = clr_cnt_q;
    done_d      = 1'b0;
    fifo_pop    = 1'b0;
    gst_ready   = 1'b0;
    vram_en_d   = 1'b0;
    vram_addr_d = vram_addr_q;
    vram_data_d = vram_data_q;

    unique case (state_q)
      StArb: begin
        gst_ready = fifo_empty || (burst_q == BurstMax);
        // Mouse head wins until the burst limit; at the limit it still wins
        // if gst has nothing to offer, so the slot is never wasted.
        if (!fifo_empty && ((burst_q < BurstMax) || !gst_wr_en_i)) begin
          fifo_pop    = 1'b1;
          vram_en_d   = 1'b1;
          vram_addr_d = fifo_dout[EntryW-1:DATA_WIDTH];
          vram_data_d = fifo_dout[DATA_WIDTH-1:0];
          if (burst_q < BurstMax) burst_d = burst_q + 1'b1;
        end else if (gst_ready && gst_wr_en_i) begin
          vram_en_d   = 1'b1;
          vram_addr_d = gst_wr_address_i;
          vram_data_d = gst_wr_data_i;
          burst_d     = '0;
        end
        // This cycle's grant still goes out; the clear starts next cycle.
        if (clr_start_i) begin
          state_d   = StClear;
          clr_cnt_d = '0;
        end
      end

      StClear: begin
        vram_en_d   = 1'b1;
        vram_addr_d = ADDR_WIDTH'(clr_cnt_q);
        vram_data_d = DATA_WIDTH'(CELL_EMPTY);
        if (clr_cnt_q == ClrLast) begin
          state_d   = StArb;
          clr_cnt_d = '0;
          done_d    = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end

      default: state_d = StArb;
    endcase

    if (fifo_empty) burst_d = '0;
  end

  // State, counters and the registered VRAM write port.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StArb;
      burst_q     <= '0;
      clr_cnt_q   <= '0;
      done_q      <= 1'b0;
      drop_q      <= 1'b0;
      vram_en_q   <= 1'b0;
      vram_addr_q <= '0;
      vram_data_q <= '0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      clr_cnt_q   <= clr_cnt_d;
      done_q      <= done_d;
      drop_q      <= drop_d;
      vram_en_q   <= vram_en_d;
      vram_addr_q <= vram_addr_d;
      vram_data_q <= vram_data_d;
    end
  end

  assign gst_ready_o       = gst_ready;
  assign mpd_ready_o       = !fifo_full;
  assign mpd_drop_o        = drop_q;
  assign clr_busy_o        = (state_q == StClear);
  assign clr_done_o        = done_q;
  assign vram_wr_en_o      = vram_en_q;
  assign vram_wr_address_o = vram_addr_q;
  assign vram_wr_data_o    = vram_data_q;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Scoreboard bench for vram_write_arbiter: stimulus pushes expected VRAM writes,
// a negedge monitor pops and compares every write the DUT presents.
module tb_vram_write_arbiter;

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 2;
  localparam int unsigned RL = 16;
  localparam int unsigned FD = 4;
  localparam int unsigned MB = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          gst_wr_en, mpd_wr_en, clr_start;
  logic [AW-1:0] gst_wr_address, mpd_wr_address;
  logic [DW-1:0] gst_wr_data, mpd_wr_data;
  logic          gst_ready, mpd_ready, mpd_drop, clr_busy, clr_done;
  logic          vram_wr_en;
  logic [AW-1:0] vram_wr_address;
  logic [DW-1:0] vram_wr_data;

  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] exp_w;
  int unsigned      n_cmp = 0;
  int unsigned      n_bad = 0;
  int unsigned      done_cnt = 0;
  int unsigned      drop_cnt = 0;

  always #5 clk = ~clk;

  vram_write_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RAM_LENGTH(RL),
    .FIFO_DEPTH(FD),
    .MAX_BURST (MB)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .gst_wr_en_i      (gst_wr_en),
    .gst_wr_address_i (gst_wr_address),
    .gst_wr_data_i    (gst_wr_data),
    .gst_ready_o      (gst_ready),
    .mpd_wr_en_i      (mpd_wr_en),
    .mpd_wr_address_i (mpd_wr_address),
    .mpd_wr_data_i    (mpd_wr_data),
    .mpd_ready_o      (mpd_ready),
    .mpd_drop_o       (mpd_drop),
    .clr_start_i      (clr_start),
    .clr_busy_o       (clr_busy),
    .clr_done_o       (clr_done),
    .vram_wr_en_o     (vram_wr_en),
    .vram_wr_address_o(vram_wr_address),
    .vram_wr_data_o   (vram_wr_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_wr(input int unsigned a, input int unsigned d);
    exp_q.push_back({AW'(a), DW'(d)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    gst_wr_en      = 1'b0;
    gst_wr_address = '0;
    gst_wr_data    = '0;
    mpd_wr_en      = 1'b0;
    mpd_wr_address = '0;
    mpd_wr_data    = '0;
    clr_start      = 1'b0;
  endtask

  // Monitor: every presented VRAM write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (clr_done) done_cnt++;
      if (mpd_drop) drop_cnt++;
      if (vram_wr_en) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL vram_unexpected: got write addr %0d data %0d, expected none (t=%0t)",
                   vram_wr_address, vram_wr_data, $time);
        end else begin
          exp_w = exp_q.pop_front();
          check("vram_write", 32'({vram_wr_address, vram_wr_data}), 32'(exp_w));
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_vram_en", 32'(vram_wr_en), 32'd0);
    check("rst_vram_addr", 32'(vram_wr_address), 32'd0);
    check("rst_vram_data", 32'(vram_wr_data), 32'd0);
    check("rst_gst_ready", 32'(gst_ready), 32'd1);
    check("rst_mpd_ready", 32'(mpd_ready), 32'd1);
    check("rst_busy", 32'(clr_busy), 32'd0);
    check("rst_done", 32'(clr_done), 32'd0);
    check("rst_drop", 32'(mpd_drop), 32'd0);
    reset = 1'b0;
    tick();
    tick();

    // Back-to-back gst writes with idle mouse path.
    for (int i = 0; i < 4; i++) expect_wr(100 + i, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      gst_wr_en      = 1'b1;
      gst_wr_address = AW'(100 + i);
      gst_wr_data    = 2'b01;
      #1;
      check("gst_b2b_ready", 32'(gst_ready), 32'd1);
    end
    tick();
    idle();
    repeat (3) tick();

    // Burst fairness: 8 mouse grants, then one forced gst slot.
    expect_wr(600, 3);
    for (int i = 0; i < 8; i++) expect_wr(700 + i, 1);
    expect_wr(600, 3);
    for (int i = 8; i < 16; i++) expect_wr(700 + i, 1);
    expect_wr(600, 3);
    for (int i = 16; i < 20; i++) expect_wr(700 + i, 1);
    for (int c = 0; c < 25; c++) begin
      tick();
      idle();
      if (c <= 19) begin
        gst_wr_en      = 1'b1;
        gst_wr_address = AW'(600);
        gst_wr_data    = 2'b11;
        mpd_wr_en      = 1'b1;
        mpd_wr_address = AW'(700 + c);
        mpd_wr_data    = 2'b01;
        #1;
        check("burst_gst_ready", 32'(gst_ready), 32'((c == 0) || (c == 9) || (c == 18)));
      end
    end
    idle();
    repeat (2) tick();

    // Clear with mouse pushes (overflowing the FIFO), held gst and a re-start.
    for (int k = 0; k < RL; k++) expect_wr(k, 0);
    for (int i = 0; i < 4; i++) expect_wr(40 + i, 2);
    expect_wr(300, 3);
    for (int j = 0; j < 26; j++) begin
      tick();
      idle();
      clr_start = (j == 0) || (j == 10);
      if (j >= 3 && j <= 21) begin
        gst_wr_en      = 1'b1;
        gst_wr_address = AW'(300);
        gst_wr_data    = 2'b11;
      end
      if (j >= 3 && j <= 8) begin
        mpd_wr_en      = 1'b1;
        mpd_wr_address = AW'(40 + j - 3);
        mpd_wr_data    = 2'b10;
      end
      #1;
      check("clr_busy", 32'(clr_busy), 32'((j >= 1) && (j <= 16)));
      check("clr_gst_ready", 32'(gst_ready), 32'(!((j >= 1) && (j <= 20))));
      check("clr_mpd_ready", 32'(mpd_ready), 32'(!((j >= 7) && (j <= 17))));
      check("clr_done", 32'(clr_done), 32'(j == 17));
      check("clr_drop", 32'(mpd_drop), 32'((j == 8) || (j == 9)));
    end
    idle();
    repeat (2) tick();

    // Reset while the clear counter is at address 7.
    for (int k = 0; k < 7; k++) expect_wr(k, 0);
    for (int j = 0; j < 9; j++) begin
      tick();
      idle();
      clr_start = (j == 0);
    end
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midclr_vram_en", 32'(vram_wr_en), 32'd0);
    check("midclr_vram_addr", 32'(vram_wr_address), 32'd0);
    check("midclr_vram_data", 32'(vram_wr_data), 32'd0);
    check("midclr_busy", 32'(clr_busy), 32'd0);
    check("midclr_done", 32'(clr_done), 32'd0);
    check("midclr_gst_ready", 32'(gst_ready), 32'd1);
    check("midclr_mpd_ready", 32'(mpd_ready), 32'd1);
    check("midclr_queue", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    expect_wr(500, 1);
    gst_wr_en      = 1'b1;
    gst_wr_address = AW'(500);
    gst_wr_data    = 2'b01;
    #1;
    check("post_reset_gst_ready", 32'(gst_ready), 32'd1);
    tick();
    idle();
    repeat (5) tick();

    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("drop_pulses", 32'(drop_cnt), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
